key_event_queue: RTL
====================

# key_event_queue

Converts the debounced push-button levels produced by the debounce stage into discrete, timestamped key events (press, release, long-hold) and buffers them in a small FIFO for the game/judge logic. It sits directly downstream of the per-button debouncers, one lane per button. It presents a valid/ready stream so the consumer can drain events at its own pace without losing simultaneous presses.

## Interface
- LANES, 4, number of button lanes (1..8)
- HOLD_CYCLES, 25_000_000, cycles a key must stay pressed after its press edge to emit a hold event (≥2)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- TS_W, 16, timestamp width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pbreg  in  LANES  debounced button levels, 1 = pressed, synchronous to clk
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready at a clk edge
- ev_lane  out  max(1,clog2(LANES))  lane of head event
- ev_kind  out  2  00 press, 01 release, 10 hold, 11 unused
- ev_time  out  TS_W  timestamp captured at event detection
- ev_count  out  clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: an event was dropped
- clr_overflow  in  1  synchronous clear of overflow

## Operation
- Free-running timestamp counter ts, TS_W bits, +1 every cycle, wraps 2^TS_W-1 -> 0.
- Per lane: prev level register; press = pbreg & ~prev; release = ~pbreg & prev.
- Per lane hold counter: cleared on press; increments while pbreg high and hold not yet fired; hold event when counter reaches HOLD_CYCLES-1 (i.e. HOLD_CYCLES edges after the press-detecting edge); fires at most once per press; release before then suppresses it.
- A lane detects at most one event per edge (press/release/hold mutually exclusive).
- Per-lane pending slot {kind, ts}: detected event loads the slot with current ts value. If slot already occupied, new event is dropped and overflow set.
- Arbiter: one push per cycle, fixed priority, lowest lane index first, only when FIFO not full; pushed lane's slot clears same edge (a new event on that lane at the same edge loads the freed slot, no drop).
- FIFO: first-word-fall-through; ev_* combinationally reflect head entry; push and pop in same cycle when not full and not empty leave ev_count unchanged. Push when full not permitted (pending waits). Pop when empty ignored.
- overflow: set on drop, cleared by clr_overflow; set wins if both same edge.

## Timing
- Reset values: ts=0, prev=0, hold counters=0, all pending empty, FIFO empty, ev_valid=0, ev_count=0, overflow=0; ev_lane/ev_kind/ev_time=0 while empty.
- prev=0 after reset: a key held through reset yields a press event at the first edge after rst deasserts.
- Latency: pbreg rises before edge k -> slot loaded at edge k with ts(k) -> pushed at edge k+1 (if top priority, not full) -> ev_valid=1 after edge k+1.
- N simultaneous presses reach the FIFO on N consecutive edges, lane order ascending, identical ev_time.
- Full FIFO: pending slots hold; drained one per edge after pops free space; ev_ready alone never drops data.
- Reset mid-operation clears everything immediately (asynchronous), including queued events and overflow.

## Test plan
- Lane 1 press at ts=100, release 20 cycles later, ev_ready=1 -> events {lane1, press, 100} then {lane1, release, 120}, ev_valid each 2 cycles after edge.
- Lanes 0 and 2 rise same cycle at ts=50 -> {0,press,50} then {2,press,50} on consecutive cycles.
- HOLD_CYCLES=8: lane 3 held 20 cycles -> press at t, hold at t+8, release at t+20; held 5 cycles -> no hold.
- ev_ready=0, DEPTH=8, toggle lane 0 repeatedly -> ev_count saturates at 8, one pending kept, next lane-0 event sets overflow; clr_overflow clears it; draining returns remaining 9 events in order.
- ts wrap with TS_W=4: press at ts=15 and release 2 cycles later -> ev_time 15 then 1.
- Assert rst with 3 queued events and lane 2 held -> ev_valid=0, ev_count=0 immediately; after release of rst, press event on lane 2.

Source files
------------

// File: rtl/key_event_queue.sv
// Turns debounced button levels into timestamped press/release/hold events
// and queues them in a first-word-fall-through FIFO with a valid/ready head.
module key_event_queue #(
   parameter int LANES       = 4,
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int DEPTH       = 8,
   parameter int TS_W        = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [LANES-1:0]                    pbreg,
   output logic                                ev_valid,
   input  logic                                ev_ready,
   output logic [(LANES > 1 ? $clog2(LANES) : 1)-1:0] ev_lane,
   output logic [1:0]                          ev_kind,
   output logic [TS_W-1:0]                     ev_time,
   output logic [$clog2(DEPTH):0]              ev_count,
   output logic                                overflow,
   input  logic                                clr_overflow
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLD_CYCLES);

   typedef enum logic [1:0] {
      K_PRESS   = 2'b00,
      K_RELEASE = 2'b01,
      K_HOLD    = 2'b10
   } kind_t;

   logic [TS_W-1:0]  ts;
   logic [LANES-1:0] prev;
   logic [LANES-1:0] fired;
   logic [HW-1:0]    hcnt [LANES];

   logic [LANES-1:0] pend_v;
   kind_t            pend_kind [LANES];
   logic [TS_W-1:0]  pend_ts [LANES];

   logic [LANES-1:0] press, rel, hold_det, det, grant, drop;
   kind_t            det_kind [LANES];

   logic             push, pop, full, empty;
   logic [LW-1:0]    push_lane;
   kind_t            push_kind;
   logic [TS_W-1:0]  push_ts;

   kind_t            mem_kind [DEPTH];
   logic [LW-1:0]    mem_lane [DEPTH];
   logic [TS_W-1:0]  mem_ts [DEPTH];
   logic [CW-1:0]    wptr, rptr, count;

   always_comb begin
      press    = '0;
      rel      = '0;
      hold_det = '0;
      det      = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         det_kind[i] = K_PRESS;
         press[i]    = pbreg[i] & ~prev[i];
         rel[i]      = ~pbreg[i] & prev[i];
         hold_det[i] = pbreg[i] & prev[i] & ~fired[i] & (hcnt[i] == HW'(HOLD_CYCLES - 1));
         det[i]      = press[i] | rel[i] | hold_det[i];
         if (rel[i])
            det_kind[i] = K_RELEASE;
         else if (hold_det[i])
            det_kind[i] = K_HOLD;
      end
   end

   assign count = wptr - rptr;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign pop   = ~empty & ev_ready;

   // Fixed-priority pick: lowest pending lane wins whenever the FIFO has room.
   always_comb begin
      grant     = '0;
      push_lane = '0;
      push_kind = K_PRESS;
      push_ts   = '0;
      if (!full) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (pend_v[i] && grant == '0) begin
               grant[i]  = 1'b1;
               push_lane = LW'(i);
               push_kind = pend_kind[i];
               push_ts   = pend_ts[i];
            end
         end
      end
   end

   assign push = |grant;
   assign drop = det & pend_v & ~grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts       <= '0;
         prev     <= '0;
         fired    <= '0;
         pend_v   <= '0;
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) begin
            hcnt[i]      <= '0;
            pend_kind[i] <= K_PRESS;
            pend_ts[i]   <= '0;
         end
      end else begin
         ts   <= ts + TS_W'(1);
         prev <= pbreg;
         for (int unsigned i = 0; i < LANES; i++) begin
            if (press[i]) begin
               hcnt[i]  <= '0;
               fired[i] <= 1'b0;
            end else if (hold_det[i]) begin
               fired[i] <= 1'b1;
            end else if (pbreg[i] && prev[i] && !fired[i]) begin
               hcnt[i] <= hcnt[i] + HW'(1);
            end
            // A slot drained this edge can take the lane's new event without a drop.
            if (det[i] && (!pend_v[i] || grant[i])) begin
               pend_v[i]    <= 1'b1;
               pend_kind[i] <= det_kind[i];
               pend_ts[i]   <= ts;
            end else if (grant[i]) begin
               pend_v[i] <= 1'b0;
            end
         end
         if (push)
            wptr <= wptr + CW'(1);
         if (pop)
            rptr <= rptr + CW'(1);
         if (|drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_kind[wptr[AW-1:0]] <= push_kind;
         mem_lane[wptr[AW-1:0]] <= push_lane;
         mem_ts[wptr[AW-1:0]]   <= push_ts;
      end
   end

   assign ev_valid = ~empty;
   assign ev_count = count;
   assign ev_lane  = empty ? '0 : mem_lane[rptr[AW-1:0]];
   assign ev_kind  = empty ? 2'b00 : mem_kind[rptr[AW-1:0]];
   assign ev_time  = empty ? '0 : mem_ts[rptr[AW-1:0]];

endmodule
